ysyx_22050039_idu_pipe: RTL and testbench

Pipelined, parametrised successor to the single-cycle decode unit. It sits between IFU and EXU. It accepts one instruction per cycle over a valid/ready handshake, decodes it, and reads operands from an internal NR_REG×XLEN register file with write-back bypass. A per-register scoreboard stalls on RAW/WAW hazards, and the decoded bundle is held in a one-entry output register toward EXU.

---
 rtl/ysyx_22050039_idu_pipe_if.sv | 42 ++++
 rtl/ysyx_22050039_idu_pipe.sv | 190 +++++++++++++++++++
 tb/tb_ysyx_22050039_idu_pipe.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050039_idu_pipe_if.sv
// IFU -> IDU -> EXU handshake bundle, write-back port and debug view of the
// pipelined decode unit. "slave" is the IDU side, "master" its environment.
interface ysyx_22050039_idu_pipe_if #(
    parameter int XLEN     = 64,
    parameter int NR_REG   = 32,
    parameter int REG_SEL  = 5,
    parameter int FUNC_LEN = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_inst;
    logic [XLEN-1:0]     in_pc;
    logic                out_valid;
    logic                out_ready;
    logic [FUNC_LEN-1:0] out_func;
    logic [5:0]          out_type;
    logic [XLEN-1:0]     out_src1;
    logic [XLEN-1:0]     out_src2;
    logic [XLEN-1:0]     out_imm;
    logic [XLEN-1:0]     out_pc;
    logic [REG_SEL-1:0]  out_rd;
    logic                out_rf_wen;
    logic                out_pc_wen;
    logic                out_illegal;
    logic                wb_valid;
    logic [REG_SEL-1:0]  wb_rd;
    logic [XLEN-1:0]     wb_data;
    logic                flush;
    logic [NR_REG-1:0]   dbg_busy;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready, wb_valid, wb_rd, wb_data, flush,
        output in_ready, out_valid, out_func, out_type, out_src1, out_src2, out_imm,
               out_pc, out_rd, out_rf_wen, out_pc_wen, out_illegal, dbg_busy
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready, wb_valid, wb_rd, wb_data, flush,
        input  in_ready, out_valid, out_func, out_type, out_src1, out_src2, out_imm,
               out_pc, out_rd, out_rf_wen, out_pc_wen, out_illegal, dbg_busy
    );
endinterface

// File: rtl/ysyx_22050039_idu_pipe.sv
// Pipelined RV64I-subset decode stage: register file with write-back bypass,
// per-register busy scoreboard for RAW/WAW stalls, one-entry output register.
module ysyx_22050039_idu_pipe #(
    parameter int XLEN     = 64,
    parameter int NR_REG   = 32,
    parameter int REG_SEL  = 5,
    parameter int FUNC_LEN = 5,
    parameter int BYPASS   = 1
) (
    input logic                      clk,
    input logic                      rst,
    ysyx_22050039_idu_pipe_if.slave  io
);
    localparam logic [FUNC_LEN-1:0] OP_INVALID = FUNC_LEN'(0);
    localparam logic [FUNC_LEN-1:0] OP_ADD     = FUNC_LEN'(1);
    localparam logic [FUNC_LEN-1:0] OP_SUB     = FUNC_LEN'(2);
    localparam logic [FUNC_LEN-1:0] OP_ADDI    = FUNC_LEN'(3);
    localparam logic [FUNC_LEN-1:0] OP_LD      = FUNC_LEN'(4);
    localparam logic [FUNC_LEN-1:0] OP_JALR    = FUNC_LEN'(5);
    localparam logic [FUNC_LEN-1:0] OP_SD      = FUNC_LEN'(6);
    localparam logic [FUNC_LEN-1:0] OP_BEQ     = FUNC_LEN'(7);
    localparam logic [FUNC_LEN-1:0] OP_BNE     = FUNC_LEN'(8);
    localparam logic [FUNC_LEN-1:0] OP_LUI     = FUNC_LEN'(9);
    localparam logic [FUNC_LEN-1:0] OP_AUIPC   = FUNC_LEN'(10);
    localparam logic [FUNC_LEN-1:0] OP_JAL     = FUNC_LEN'(11);
    localparam logic [FUNC_LEN-1:0] OP_EBREAK  = FUNC_LEN'(12);

    logic [XLEN-1:0]     r_rf [NR_REG];
    logic [NR_REG-1:0]   r_busy;
    logic                r_out_valid;
    logic [FUNC_LEN-1:0] r_out_func;
    logic [5:0]          r_out_type;
    logic [XLEN-1:0]     r_out_src1, r_out_src2, r_out_imm, r_out_pc;
    logic [REG_SEL-1:0]  r_out_rd;
    logic                r_out_rf_wen, r_out_pc_wen, r_out_illegal;

    logic [31:0]         w_inst;
    logic [6:0]          w_opcode;
    logic [2:0]          w_f3;
    logic [6:0]          w_f7;
    logic [REG_SEL-1:0]  w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0]     w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [FUNC_LEN-1:0] w_func;
    logic [5:0]          w_type;
    logic [XLEN-1:0]     w_imm, w_src1, w_src2, w_rdata1, w_rdata2;
    logic                w_rf_wen, w_pc_wen, w_use_rs1, w_use_rs2;
    logic                w_fwd1, w_fwd2, w_hazard, w_ready, w_fire, w_wb_en;
    logic [NR_REG-1:0]   w_clr_wb, w_clr_fl, w_set, w_busy_nxt;

    assign w_inst   = io.in_inst;
    assign w_opcode = w_inst[6:0];
    assign w_f3     = w_inst[14:12];
    assign w_f7     = w_inst[31:25];
    assign w_rs1    = w_inst[19:15];
    assign w_rs2    = w_inst[24:20];
    assign w_imm_i  = {{(XLEN-12){w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s  = {{(XLEN-12){w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b  = {{(XLEN-12){w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u  = {{(XLEN-32){w_inst[31]}}, w_inst[31:12], 12'h000};
    assign w_imm_j  = {{(XLEN-20){w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

    // Opcode/funct matching into the internal op code.
    always_comb begin
        w_func = OP_INVALID;
        if (w_inst == 32'h0010_0073) begin
            w_func = OP_EBREAK;
        end else begin
            case (w_opcode)
                7'b0110011: begin
                    if (w_f3 == 3'b000 && w_f7 == 7'b0000000)      w_func = OP_ADD;
                    else if (w_f3 == 3'b000 && w_f7 == 7'b0100000) w_func = OP_SUB;
                    else                                           w_func = OP_INVALID;
                end
                7'b0010011: w_func = (w_f3 == 3'b000) ? OP_ADDI : OP_INVALID;
                7'b0000011: w_func = (w_f3 == 3'b011) ? OP_LD   : OP_INVALID;
                7'b1100111: w_func = (w_f3 == 3'b000) ? OP_JALR : OP_INVALID;
                7'b0100011: w_func = (w_f3 == 3'b011) ? OP_SD   : OP_INVALID;
                7'b1100011: begin
                    if (w_f3 == 3'b000)      w_func = OP_BEQ;
                    else if (w_f3 == 3'b001) w_func = OP_BNE;
                    else                     w_func = OP_INVALID;
                end
                7'b0110111: w_func = OP_LUI;
                7'b0010111: w_func = OP_AUIPC;
                7'b1101111: w_func = OP_JAL;
                default:    w_func = OP_INVALID;
            endcase
        end
    end

    // Format class, one-hot {R,I,S,B,U,J}, and the matching immediate.
    always_comb begin
        w_type = 6'b000000;
        w_imm  = {XLEN{1'b0}};
        case (w_func)
            OP_ADD, OP_SUB:          w_type = 6'b100000;
            OP_ADDI, OP_LD, OP_JALR: begin w_type = 6'b010000; w_imm = w_imm_i; end
            OP_SD:                   begin w_type = 6'b001000; w_imm = w_imm_s; end
            OP_BEQ, OP_BNE:          begin w_type = 6'b000100; w_imm = w_imm_b; end
            OP_LUI, OP_AUIPC:        begin w_type = 6'b000010; w_imm = w_imm_u; end
            OP_JAL:                  begin w_type = 6'b000001; w_imm = w_imm_j; end
            default:                 begin w_type = 6'b000000; w_imm = {XLEN{1'b0}}; end
        endcase
    end

    assign w_rf_wen  = |(w_type & 6'b110011);
    assign w_pc_wen  = (w_func == OP_JAL) || (w_func == OP_JALR) ||
                       (w_func == OP_BEQ) || (w_func == OP_BNE);
    assign w_use_rs1 = |(w_type & 6'b111100);
    assign w_use_rs2 = |(w_type & 6'b101100);
    assign w_rd      = w_rf_wen ? w_inst[11:7] : REG_SEL'(0);
    assign w_wb_en   = io.wb_valid && (io.wb_rd != REG_SEL'(0));

    // A same-cycle write-back both supplies the operand and retires the hazard.
    assign w_fwd1   = (BYPASS != 0) && w_wb_en && (io.wb_rd == w_rs1);
    assign w_fwd2   = (BYPASS != 0) && w_wb_en && (io.wb_rd == w_rs2);
    assign w_rdata1 = (w_rs1 == REG_SEL'(0)) ? {XLEN{1'b0}} : (w_fwd1 ? io.wb_data : r_rf[w_rs1]);
    assign w_rdata2 = (w_rs2 == REG_SEL'(0)) ? {XLEN{1'b0}} : (w_fwd2 ? io.wb_data : r_rf[w_rs2]);
    assign w_src1   = (w_type[1] || w_type[0]) ? w_imm : (w_use_rs1 ? w_rdata1 : {XLEN{1'b0}});
    assign w_src2   = w_type[4] ? w_imm : (w_use_rs2 ? w_rdata2 : {XLEN{1'b0}});

    assign w_hazard = (w_use_rs1 && r_busy[w_rs1] && !w_fwd1) ||
                      (w_use_rs2 && r_busy[w_rs2] && !w_fwd2) ||
                      ((w_rd != REG_SEL'(0)) && r_busy[w_rd]);
    assign w_ready  = rst && !io.flush && !w_hazard && (!r_out_valid || io.out_ready);
    assign w_fire   = io.in_valid && w_ready;

    // Transfer set beats write-back clear; flush releases the killed bundle's rd.
    assign w_clr_wb   = w_wb_en ? (NR_REG'(1) << io.wb_rd) : {NR_REG{1'b0}};
    assign w_clr_fl   = (io.flush && r_out_valid && (r_out_rd != REG_SEL'(0))) ?
                        (NR_REG'(1) << r_out_rd) : {NR_REG{1'b0}};
    assign w_set      = (w_fire && (w_rd != REG_SEL'(0))) ? (NR_REG'(1) << w_rd) : {NR_REG{1'b0}};
    assign w_busy_nxt = (r_busy & ~w_clr_wb & ~w_clr_fl) | w_set;

    // Register file and scoreboard state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NR_REG; i++) r_rf[i] <= {XLEN{1'b0}};
            r_busy <= {NR_REG{1'b0}};
        end else begin
            if (w_wb_en) r_rf[io.wb_rd] <= io.wb_data;
            r_busy <= w_busy_nxt;
        end
    end

    // One-entry output register toward EXU.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid   <= 1'b0;
            r_out_func    <= OP_INVALID;
            r_out_type    <= 6'b000000;
            r_out_src1    <= {XLEN{1'b0}};
            r_out_src2    <= {XLEN{1'b0}};
            r_out_imm     <= {XLEN{1'b0}};
            r_out_pc      <= {XLEN{1'b0}};
            r_out_rd      <= REG_SEL'(0);
            r_out_rf_wen  <= 1'b0;
            r_out_pc_wen  <= 1'b0;
            r_out_illegal <= 1'b0;
        end else if (w_fire) begin
            r_out_valid   <= 1'b1;
            r_out_func    <= w_func;
            r_out_type    <= w_type;
            r_out_src1    <= w_src1;
            r_out_src2    <= w_src2;
            r_out_imm     <= w_imm;
            r_out_pc      <= io.in_pc;
            r_out_rd      <= w_rd;
            r_out_rf_wen  <= w_rf_wen;
            r_out_pc_wen  <= w_pc_wen;
            r_out_illegal <= (w_func == OP_INVALID);
        end else if (io.flush || io.out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign io.in_ready    = w_ready;
    assign io.out_valid   = r_out_valid;
    assign io.out_func    = r_out_func;
    assign io.out_type    = r_out_type;
    assign io.out_src1    = r_out_src1;
    assign io.out_src2    = r_out_src2;
    assign io.out_imm     = r_out_imm;
    assign io.out_pc      = r_out_pc;
    assign io.out_rd      = r_out_rd;
    assign io.out_rf_wen  = r_out_rf_wen;
    assign io.out_pc_wen  = r_out_pc_wen;
    assign io.out_illegal = r_out_illegal;
    assign io.dbg_busy    = r_busy;
endmodule

// File: tb/tb_ysyx_22050039_idu_pipe.sv
// Scoreboard bench for the pipelined decode unit: expected bundles are queued
// as instructions are accepted and compared when EXU takes them.
module tb_ysyx_22050039_idu_pipe;
    localparam logic [5:0] T_R = 6'b100000, T_I = 6'b010000, T_S = 6'b001000;
    localparam logic [5:0] T_B = 6'b000100, T_U = 6'b000010, T_J = 6'b000001;

    typedef struct packed {
        logic [4:0]  func;
        logic [5:0]  typ;
        logic [63:0] src1;
        logic [63:0] src2;
        logic [63:0] imm;
        logic [63:0] pc;
        logic [4:0]  rd;
        logic        rf_wen;
        logic        pc_wen;
        logic        illegal;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;
    int   waited;
    exp_t sbq[$];
    exp_t mon_e;

    ysyx_22050039_idu_pipe_if #(.XLEN(64), .NR_REG(32), .REG_SEL(5), .FUNC_LEN(5)) bus ();

    ysyx_22050039_idu_pipe #(.XLEN(64), .NR_REG(32), .REG_SEL(5), .FUNC_LEN(5), .BYPASS(1)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] func, input logic [5:0] typ,
                                input logic [63:0] src1, input logic [63:0] src2,
                                input logic [63:0] imm, input logic [63:0] pc,
                                input logic [4:0] rd, input logic rf_wen,
                                input logic pc_wen, input logic illegal);
        exp_t e;
        e.func = func; e.typ = typ; e.src1 = src1; e.src2 = src2; e.imm = imm;
        e.pc = pc; e.rd = rd; e.rf_wen = rf_wen; e.pc_wen = pc_wen; e.illegal = illegal;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] inst, input logic [63:0] pc, input exp_t e,
                         output int wcnt);
        bus.in_inst  = inst;
        bus.in_pc    = pc;
        bus.in_valid = 1'b1;
        wcnt = 0;
        @(negedge clk);
        while (!bus.in_ready && wcnt < 20) begin
            wcnt++;
            @(negedge clk);
        end
        if (bus.in_ready) sbq.push_back(e);
        else check_val("accept_timeout", 64'd0, 64'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [63:0] data);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd;
        bus.wb_data  = data;
        tick();
        bus.wb_valid = 1'b0;
    endtask

    // Scoreboard: compare each bundle EXU takes against the oldest expectation.
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
                check_val("sb_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                check_val("func",    64'(bus.out_func),    64'(mon_e.func));
                check_val("type",    64'(bus.out_type),    64'(mon_e.typ));
                check_val("src1",    bus.out_src1,         mon_e.src1);
                check_val("src2",    bus.out_src2,         mon_e.src2);
                check_val("imm",     bus.out_imm,          mon_e.imm);
                check_val("pc",      bus.out_pc,           mon_e.pc);
                check_val("rd",      64'(bus.out_rd),      64'(mon_e.rd));
                check_val("rf_wen",  64'(bus.out_rf_wen),  64'(mon_e.rf_wen));
                check_val("pc_wen",  64'(bus.out_pc_wen),  64'(mon_e.pc_wen));
                check_val("illegal", 64'(bus.out_illegal), 64'(mon_e.illegal));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

    logic [31:0] corner_inst [8];
    exp_t        corner_exp  [8];

    initial begin
        bus.in_valid = 1'b1; bus.in_inst = 32'h0050_0093; bus.in_pc = 64'd0;
        bus.out_ready = 1'b1; bus.wb_valid = 1'b0; bus.wb_rd = 5'd0;
        bus.wb_data = 64'd0; bus.flush = 1'b0;

        // Reset with an instruction on offer.
        repeat (2) @(negedge clk);
        check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_in_ready",  64'(bus.in_ready),  64'd0);
        check_val("rst_busy",      64'(bus.dbg_busy),  64'd0);
        check_val("rst_src1",      bus.out_src1,       64'd0);
        check_val("rst_func",      64'(bus.out_func),  64'd0);
        tick();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        tick();

        // addi x1,x0,5 then dependent addi x2,x1,1 resolved by bypass.
        issue(32'h0050_0093, 64'h8000_0000, mk(5'd3, T_I, 64'd0, 64'd5, 64'd5, 64'h8000_0000, 5'd1, 1'b1, 1'b0, 1'b0), waited);
        @(negedge clk);
        check_val("busy_x1", 64'(bus.dbg_busy), 64'h2);
        tick();
        bus.in_inst = 32'h0010_8113; bus.in_pc = 64'h8000_0004; bus.in_valid = 1'b1;
        @(negedge clk);
        check_val("raw_stall", 64'(bus.in_ready), 64'd0);
        tick();
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 64'd5;
        @(negedge clk);
        check_val("raw_bypass", 64'(bus.in_ready), 64'd1);
        sbq.push_back(mk(5'd3, T_I, 64'd5, 64'd1, 64'd1, 64'h8000_0004, 5'd2, 1'b1, 1'b0, 1'b0));
        tick();
        bus.wb_valid = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        check_val("busy_x2", 64'(bus.dbg_busy), 64'h4);
        tick();
        wb(5'd2, 64'd6);

        // x0 never goes busy; WAW on x3 waits for the clear.
        issue(32'h0010_0013, 64'h8000_0008, mk(5'd3, T_I, 64'd0, 64'd1, 64'd1, 64'h8000_0008, 5'd0, 1'b1, 1'b0, 1'b0), waited);
        @(negedge clk);
        check_val("x0_busy", 64'(bus.dbg_busy), 64'd0);
        tick();
        issue(32'h0070_0193, 64'h8000_000C, mk(5'd3, T_I, 64'd0, 64'd7, 64'd7, 64'h8000_000C, 5'd3, 1'b1, 1'b0, 1'b0), waited);
        bus.in_inst = 32'h0090_0193; bus.in_pc = 64'h8000_0010; bus.in_valid = 1'b1;
        @(negedge clk);
        check_val("waw_stall", 64'(bus.in_ready), 64'd0);
        tick();
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 64'd7;
        @(negedge clk);
        check_val("waw_wb_cycle", 64'(bus.in_ready), 64'd0);
        tick();
        bus.wb_valid = 1'b0;
        issue(32'h0090_0193, 64'h8000_0010, mk(5'd3, T_I, 64'd0, 64'd9, 64'd9, 64'h8000_0010, 5'd3, 1'b1, 1'b0, 1'b0), waited);
        check_val("waw_release", 64'(waited), 64'd0);
        wb(5'd3, 64'd9);

        // Backpressure holds the bundle; release transfers the next at once.
        bus.out_ready = 1'b0;
        issue(32'h1234_5237, 64'h8000_0014, mk(5'd9, T_U, 64'h1234_5000, 64'd0, 64'h1234_5000, 64'h8000_0014, 5'd4, 1'b1, 1'b0, 1'b0), waited);
        bus.in_inst = 32'h0000_1317; bus.in_pc = 64'h8000_0018; bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check_val("bp_hold_rd",  64'(bus.out_rd),   64'd4);
            check_val("bp_hold_src", bus.out_src1,      64'h1234_5000);
            tick();
        end
        bus.out_ready = 1'b1;
        issue(32'h0000_1317, 64'h8000_0018, mk(5'd10, T_U, 64'h1000, 64'd0, 64'h1000, 64'h8000_0018, 5'd6, 1'b1, 1'b0, 1'b0), waited);
        check_val("bp_release", 64'(waited), 64'd0);
        wb(5'd4, 64'h1234_5000);
        wb(5'd6, 64'h1000);

        // Decode corners, back to back (x1=5, x2=6).
        corner_inst[0] = 32'hFFDF_F06F; corner_exp[0] = mk(5'd11, T_J, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h100, 5'd0, 1'b1, 1'b1, 1'b0);
        corner_inst[1] = 32'hFE11_3C23; corner_exp[1] = mk(5'd6,  T_S, 64'd6, 64'd5, 64'hFFFF_FFFF_FFFF_FFF8, 64'h104, 5'd0, 1'b0, 1'b0, 1'b0);
        corner_inst[2] = 32'h0010_0073; corner_exp[2] = mk(5'd12, 6'd0, 64'd0, 64'd0, 64'd0, 64'h108, 5'd0, 1'b0, 1'b0, 1'b0);
        corner_inst[3] = 32'hFFFF_FFFF; corner_exp[3] = mk(5'd0,  6'd0, 64'd0, 64'd0, 64'd0, 64'h10C, 5'd0, 1'b0, 1'b0, 1'b1);
        corner_inst[4] = 32'h0020_83B3; corner_exp[4] = mk(5'd1,  T_R, 64'd5, 64'd6, 64'd0, 64'h110, 5'd7, 1'b1, 1'b0, 1'b0);
        corner_inst[5] = 32'h4011_0433; corner_exp[5] = mk(5'd2,  T_R, 64'd6, 64'd5, 64'd0, 64'h114, 5'd8, 1'b1, 1'b0, 1'b0);
        corner_inst[6] = 32'h0020_8463; corner_exp[6] = mk(5'd7,  T_B, 64'd5, 64'd6, 64'd8, 64'h118, 5'd0, 1'b0, 1'b1, 1'b0);
        corner_inst[7] = 32'h0100_B483; corner_exp[7] = mk(5'd4,  T_I, 64'd5, 64'd16, 64'd16, 64'h11C, 5'd9, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            issue(corner_inst[i], 64'h100 + 64'(4 * i), corner_exp[i], waited);
            check_val("corner_no_stall", 64'(waited), 64'd0);
        end
        wb(5'd7, 64'd11);
        wb(5'd8, 64'd1);
        wb(5'd9, 64'd0);

        // Flush a held bundle with rd=5; concurrent offer is refused.
        bus.out_ready = 1'b0;
        issue(32'h0030_0293, 64'h200, mk(5'd3, T_I, 64'd0, 64'd3, 64'd3, 64'h200, 5'd5, 1'b1, 1'b0, 1'b0), waited);
        @(negedge clk);
        check_val("fl_busy_set", 64'(bus.dbg_busy), 64'h20);
        tick();
        bus.flush = 1'b1; bus.in_inst = 32'h0010_0013; bus.in_pc = 64'h204; bus.in_valid = 1'b1;
        @(negedge clk);
        check_val("fl_concurrent", 64'(bus.in_ready), 64'd0);
        tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        void'(sbq.pop_back());
        @(negedge clk);
        check_val("fl_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("fl_busy_clr",  64'(bus.dbg_busy),  64'd0);
        tick();

        // Reset while a bundle is held and a dependent instruction stalls.
        issue(32'h0030_0293, 64'h300, mk(5'd3, T_I, 64'd0, 64'd3, 64'd3, 64'h300, 5'd5, 1'b1, 1'b0, 1'b0), waited);
        bus.in_inst = 32'h0012_8313; bus.in_pc = 64'h304; bus.in_valid = 1'b1;
        @(negedge clk);
        check_val("rs_stall", 64'(bus.in_ready), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check_val("rs_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rs_busy",      64'(bus.dbg_busy),  64'd0);
        check_val("rs_src2",      bus.out_src2,       64'd0);
        check_val("rs_in_ready",  64'(bus.in_ready),  64'd0);
        sbq.delete();
        tick();
        rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_val("sb_drain", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
